turbo_out_arb: RTL
==================

Name: turbo_out_arb

Overview:
- Round-robin, packet-atomic arbiter that shares one parallel output bus among NUM_LANE turbo-decoder output lanes. Each lane is an ST-to-bus converter that emits one turbo packet as NUM_BUS_PER_TURBO_PKT bus words.
- Sits in the clk_bus domain, between the per-lane converters and the AFU output/memory-write path.
- Grants one lane at a time, forwards that lane's words with one cycle of registered latency, and inserts a programmable idle gap between packets.
- A watchdog aborts a granted lane that stalls mid-packet.

Parameters:
- NUM_LANE, 4, number of requesting lanes (≥2)
- ST_PER_BUS, 512, bus word width in bits
- NUM_BUS_PER_TURBO_PKT, 2, bus words per turbo packet (≥1)
- GAP_CYCLES, 2, idle cycles inserted after each packet (≥0)
- TIMEOUT, 255, max cycles in XFER with no lane_en before abort (≥1)
- LW, $clog2(NUM_LANE), lane index width

Ports:
- clk_bus  in  1  400 MHz bus clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- lane_req  in  NUM_LANE  lane i holds a complete packet and requests the bus; level
- lane_data  in  NUM_LANE*ST_PER_BUS  lane i word at [i*ST_PER_BUS +: ST_PER_BUS]
- lane_en  in  NUM_LANE  lane i word valid this cycle
- lane_ready  out  NUM_LANE  per-lane bus_ready; at most one bit high
- out_ready  in  1  downstream can accept words
- out_data  out  ST_PER_BUS  forwarded word
- out_en  out  1  out_data valid
- out_lane  out  LW  lane index that owns out_data
- pkt_cnt  out  16  completed-packet counter, wraps
- abort_err  out  1  sticky; set on watchdog abort
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: asserting rst asynchronously drives the following, and holds them while rst is high:
  - FSM=IDLE, lane_ready=0, out_data=0, out_en=0, out_lane=0, pkt_cnt=0, abort_err=0, busy=0.
  - last_grant=NUM_LANE-1, so lane 0 has first priority.
  - Word counter and gap counter cleared.
  - A reset mid-packet discards the packet and does not increment pkt_cnt.
- FSM states: IDLE, XFER, GAP.
- IDLE:
  - If any lane_req bit is high, grant the first requesting lane at index (last_grant+1..last_grant+NUM_LANE) mod NUM_LANE.
  - On the next edge: latch grant, out_lane<=grant, last_grant<=grant, go to XFER.
  - If no lane requests, stay in IDLE.
- XFER:
  - lane_ready[grant]=out_ready, combinational. All other lane_ready bits are 0.
  - Each cycle with lane_en[grant]=1: out_data<=lane word, out_en<=1, word counter +1. Otherwise out_en<=0 and out_data holds.
  - lane_en from non-granted lanes is ignored.
  - lane_req deasserting mid-packet is ignored; the grant is packet-atomic.
  - On the word with counter==NUM_BUS_PER_TURBO_PKT-1: pkt_cnt+1 (wrapping 0xFFFF→0), counter cleared, go to GAP.
- out_en is a push: it is not gated by out_ready. out_ready only throttles the lane, and the downstream must absorb one in-flight word after dropping out_ready.
- Latency: lane_en → out_en is exactly 1 cycle.
- Watchdog:
  - A counter in XFER counts consecutive cycles with lane_en[grant]=0. It resets on every granted word and on state entry.
  - When it reaches TIMEOUT: abort_err<=1 (sticky until rst), no pkt_cnt increment, go to GAP.
  - The lane rotation still advances past the aborted lane.
- GAP:
  - lane_ready=0, out_en<=0.
  - Stay GAP_CYCLES cycles, then go to IDLE.
  - GAP_CYCLES=0 means GAP lasts 1 cycle (the transition cycle only).
- Arbitration is evaluated only in IDLE. Requests arriving in XFER or GAP wait.
- Simultaneous requests resolve by rotation only. No lane wins twice while another lane is requesting.
- busy=1 in XFER and GAP.

Test Plan:
- Single lane, NUM_BUS_PER_TURBO_PKT=2: lane 2 req, lane_en on 2 consecutive cycles with data 0xA…A, 0xB…B → out_en high 2 cycles, each 1 cycle after lane_en, data matches, out_lane=2, pkt_cnt=1, then ≥GAP_CYCLES idle cycles.
- All 4 lanes req continuously for 8 packets → grant order 0,1,2,3,0,1,2,3; pkt_cnt=8; lane_ready never has >1 bit high.
- out_ready toggled 1,0,0,1 during lane 1 transfer → lane_ready[1] mirrors out_ready combinationally; no word lost or duplicated; out_en count = 2 per packet.
- Granted lane 3 sends 1 word then stalls; TIMEOUT=255 → abort after 255 idle cycles, abort_err=1, pkt_cnt unchanged, next grant is lane 0 if requesting.
- rst pulsed high while in XFER after word 1 → outputs return to reset values immediately; after release, lane 0 is served first and pkt_cnt restarts at 0.
- Non-granted lane 0 drives lane_en=1 during lane 1 packet → out_data carries only lane 1 words.

Source files
------------

// File: rtl/turbo_out_arb.sv
// Round-robin, packet-atomic arbiter sharing one output bus among turbo-decoder lanes.
// Forwards the granted lane's words with one registered cycle, then holds an idle gap.
module turbo_out_arb #(
    parameter int NUM_LANE              = 4,
    parameter int ST_PER_BUS            = 512,
    parameter int NUM_BUS_PER_TURBO_PKT = 2,
    parameter int GAP_CYCLES            = 2,
    parameter int TIMEOUT               = 255,
    parameter int LW                    = $clog2(NUM_LANE)
) (
    input  logic                           clk_bus,
    input  logic                           rst,
    input  logic [NUM_LANE-1:0]            lane_req,
    input  logic [NUM_LANE*ST_PER_BUS-1:0] lane_data,
    input  logic [NUM_LANE-1:0]            lane_en,
    output logic [NUM_LANE-1:0]            lane_ready,
    input  logic                           out_ready,
    output logic [ST_PER_BUS-1:0]          out_data,
    output logic                           out_en,
    output logic [LW-1:0]                  out_lane,
    output logic [15:0]                    pkt_cnt,
    output logic                           abort_err,
    output logic                           busy
);

    localparam int WCW = (NUM_BUS_PER_TURBO_PKT > 1) ? $clog2(NUM_BUS_PER_TURBO_PKT) : 1;
    localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [WCW-1:0] WORD_LAST = WCW'(NUM_BUS_PER_TURBO_PKT - 1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);
    localparam logic [TCW-1:0] WD_LAST   = TCW'(TIMEOUT - 1);
    localparam logic [LW-1:0]  LANE_LAST = LW'(NUM_LANE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                 state;
    logic [LW-1:0]          grant;
    logic [LW-1:0]          last_grant;
    logic [LW-1:0]          next_grant;
    logic [LW-1:0]          rr_cand;
    logic                   any_req;
    logic [WCW-1:0]         word_cnt;
    logic [GCW-1:0]         gap_cnt;
    logic [TCW-1:0]         wd_cnt;
    logic                   granted_en;
    logic [ST_PER_BUS-1:0]  granted_word;

    // Descending scan so the lane nearest after last_grant is the final (winning) match.
    always_comb begin
        next_grant = last_grant;
        any_req    = 1'b0;
        rr_cand    = '0;
        for (int k = NUM_LANE; k >= 1; k--) begin
            rr_cand = LW'((int'(last_grant) + k) % NUM_LANE);
            if (lane_req[rr_cand]) begin
                next_grant = rr_cand;
                any_req    = 1'b1;
            end
        end
    end

    always_comb begin
        granted_word = '0;
        for (int i = 0; i < NUM_LANE; i++) begin
            if (grant == LW'(i)) begin
                granted_word = lane_data[i*ST_PER_BUS +: ST_PER_BUS];
            end
        end
    end

    assign granted_en = lane_en[grant];
    assign busy       = (state != IDLE);

    always_comb begin
        lane_ready = '0;
        if (state == XFER) begin
            lane_ready[grant] = out_ready;
        end
    end

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LANE_LAST;
            word_cnt   <= '0;
            gap_cnt    <= '0;
            wd_cnt     <= '0;
            out_data   <= '0;
            out_en     <= 1'b0;
            out_lane   <= '0;
            pkt_cnt    <= '0;
            abort_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_en   <= 1'b0;
                    word_cnt <= '0;
                    wd_cnt   <= '0;
                    if (any_req) begin
                        grant      <= next_grant;
                        out_lane   <= next_grant;
                        last_grant <= next_grant;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (granted_en) begin
                        out_data <= granted_word;
                        out_en   <= 1'b1;
                        wd_cnt   <= '0;
                        if (word_cnt == WORD_LAST) begin
                            word_cnt <= '0;
                            pkt_cnt  <= pkt_cnt + 16'd1;
                            gap_cnt  <= '0;
                            state    <= GAP;
                        end else begin
                            word_cnt <= word_cnt + WCW'(1);
                        end
                    end else begin
                        out_en <= 1'b0;
                        // wd_cnt holds the idle cycles before this one, so this is idle cycle TIMEOUT.
                        if (wd_cnt == WD_LAST) begin
                            abort_err <= 1'b1;
                            word_cnt  <= '0;
                            wd_cnt    <= '0;
                            gap_cnt   <= '0;
                            state     <= GAP;
                        end else begin
                            wd_cnt <= wd_cnt + TCW'(1);
                        end
                    end
                end
                GAP: begin
                    out_en <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GCW'(1);
                    end
                end
                default: begin
                    out_en <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
